// File: rtl/reg_read_pkg.sv
// Shared constants and the response-buffer entry type for the register read port.
package reg_read_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_NUM_REGS   = 16;

    // Address width for a bank of n registers; a single register still needs one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_ADDR_WIDTH = addr_width(DEFAULT_NUM_REGS);

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic                          err;
    } resp_entry_t;

endpackage

// File: rtl/reg_read_port_resp_fifo2.sv
// Two-entry response FIFO. Slot 0 is always the head; unused slots are kept at zero
// so the head can drive response outputs directly and reads as zero when empty.
module resp_fifo2
    import reg_read_pkg::*;
#(
    parameter type entry_t = resp_entry_t
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  entry_t     push_data,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    // Next-state: push into the first free slot, pop shifts slot 1 forward.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_push = push && (count_q != 2'd2);
        do_pop  = pop  && (count_q != 2'd0);

        if (do_push && do_pop) begin
            // Only reachable with one entry held: replace it, count stays 1.
            slot0_d = push_data;
        end else if (do_push) begin
            if (count_q == 2'd0) begin
                slot0_d = push_data;
            end else begin
                slot1_d = push_data;
            end
            count_d = count_q + 2'd1;
        end else if (do_pop) begin
            slot0_d = slot1_q;
            slot1_d = '0;
            count_d = count_q - 2'd1;
        end
    end

    // Storage and occupancy, dropped entirely on clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head  = slot0_q;
    assign count = count_q;

endmodule

// File: rtl/reg_read_port.sv
// Register bank with an enable/data write port and a valid/ready read port
// returning {addr, data, err} one cycle after acceptance through a 2-entry buffer.
module reg_read_port
    import reg_read_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int unsigned NUM_REGS   = DEFAULT_NUM_REGS,
    localparam int unsigned ADDR_WIDTH = addr_width(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_req_valid,
    output logic                  read_req_ready,
    input  logic [ADDR_WIDTH-1:0] read_req_addr,
    output logic                  read_resp_valid,
    input  logic                  read_resp_ready,
    output logic [DATA_WIDTH-1:0] read_resp_data,
    output logic [ADDR_WIDTH-1:0] read_resp_addr,
    output logic                  read_resp_err
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } entry_t;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rd_data;
    entry_t                push_entry;
    entry_t                head;
    logic [1:0]            fifo_count;
    logic                  req_fire;
    logic                  resp_fire;

    assign wr_in_range = (32'(write_addr) < NUM_REGS);
    assign rd_in_range = (32'(read_req_addr) < NUM_REGS);
    assign bypass      = write_enable && (write_addr == read_req_addr);

    // Register bank: cleared on reset, out-of-range writes dropped silently.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[ADDR_WIDTH'(i)] <= '0;
            end
        end else if (write_enable && wr_in_range) begin
            regs[write_addr] <= write_data;
        end
    end

    // Read mux, guarded so out-of-range addresses never index the bank.
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = regs[read_req_addr];
        end
    end

    // Snapshot captured at acceptance; a same-cycle write to the same register wins.
    always_comb begin
        push_entry      = '0;
        push_entry.addr = read_req_addr;
        push_entry.err  = !rd_in_range;
        if (rd_in_range) begin
            push_entry.data = bypass ? write_data : rd_data;
        end
    end

    // Ready depends only on buffer occupancy and reset, never on the consumer side.
    assign read_req_ready = (fifo_count != 2'd2) && clear;
    assign req_fire       = read_req_valid && read_req_ready;
    assign resp_fire      = read_resp_valid && read_resp_ready;

    resp_fifo2 #(
        .entry_t (entry_t)
    ) u_resp_fifo (
        .clock     (clock),
        .clear     (clear),
        .push      (req_fire),
        .pop       (resp_fire),
        .push_data (push_entry),
        .head      (head),
        .count     (fifo_count)
    );

    assign read_resp_valid = (fifo_count != 2'd0);
    assign read_resp_data  = head.data;
    assign read_resp_addr  = head.addr;
    assign read_resp_err   = head.err;

endmodule

// File: tb/tb_reg_read_port.sv
// Scoreboard bench for reg_read_port (NUM_REGS = 12): stimulus pushes expected
// responses, a negedge monitor pops and compares on every response handshake.
module tb_reg_read_port;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 12;
    localparam int unsigned AW = 4;

    logic          clock = 1'b0;
    logic          clear;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          read_req_valid;
    logic          read_req_ready;
    logic [AW-1:0] read_req_addr;
    logic          read_resp_valid;
    logic          read_resp_ready;
    logic [DW-1:0] read_resp_data;
    logic [AW-1:0] read_resp_addr;
    logic          read_resp_err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic          prev_err;

    reg_read_port #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clock           (clock),
        .clear           (clear),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .read_req_valid  (read_req_valid),
        .read_req_ready  (read_req_ready),
        .read_req_addr   (read_req_addr),
        .read_resp_valid (read_resp_valid),
        .read_resp_ready (read_resp_ready),
        .read_resp_data  (read_resp_data),
        .read_resp_addr  (read_resp_addr),
        .read_resp_err   (read_resp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare each handshaked response, hold stability while stalled, zeros when idle.
    always @(negedge clock) begin
        if (read_resp_valid) begin
            if (prev_stall) begin
                check("hold_data", 64'(read_resp_data), 64'(prev_data));
                check("hold_addr", 64'(read_resp_addr), 64'(prev_addr));
                check("hold_err",  64'(read_resp_err),  64'(prev_err));
            end
            if (read_resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual addr=%0h required none", read_resp_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_addr", 64'(read_resp_addr), 64'(mon_e.addr));
                    check("resp_data", 64'(read_resp_data), 64'(mon_e.data));
                    check("resp_err",  64'(read_resp_err),  64'(mon_e.err));
                end
            end
        end else begin
            check("idle_zero", 64'({read_resp_data, read_resp_addr, read_resp_err}), 64'(0));
        end
        prev_stall = read_resp_valid && !read_resp_ready;
        prev_data  = read_resp_data;
        prev_addr  = read_resp_addr;
        prev_err   = read_resp_err;
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        @(posedge clock);
        #1;
        write_enable = 1'b0;
    endtask

    // Present a request (optionally with a concurrent write) until accepted; push expectation.
    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic er,
                         input logic w_en, input logic [AW-1:0] w_a, input logic [DW-1:0] w_d);
        bit done = 1'b0;
        read_req_valid = 1'b1;
        read_req_addr  = a;
        write_enable   = w_en;
        write_addr     = w_a;
        write_data     = w_d;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clock);
            if (read_req_ready) begin
                exp_q.push_back('{addr: a, data: d, err: er});
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        read_req_valid = 1'b0;
        write_enable   = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout actual=not_accepted required=accepted addr=%0h", a);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic er);
        issue(a, d, er, 1'b0, '0, '0);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !read_resp_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear           = 1'b0;
        write_enable    = 1'b0;
        write_addr      = '0;
        write_data      = '0;
        read_req_valid  = 1'b0;
        read_req_addr   = '0;
        read_resp_ready = 1'b1;

        // Reset state
        #2;
        check("rst_req_ready",  64'(read_req_ready),  64'(0));
        check("rst_resp_valid", 64'(read_resp_valid), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        #1;
        check("ready_after_release", 64'(read_req_ready), 64'(1));

        // 1: read R5 from reset, one-cycle latency
        rd(4'd5, 32'd0, 1'b0);
        check("lat1_valid", 64'(read_resp_valid), 64'(1));
        check("lat1_addr",  64'(read_resp_addr),  64'(5));
        drain();

        // 2: write then read
        wr(4'd3, 32'd123);
        rd(4'd3, 32'd123, 1'b0);
        check("lat2_valid", 64'(read_resp_valid), 64'(1));
        drain();

        // 3: same-cycle write bypass
        issue(4'd7, 32'hDEADBEEF, 1'b0, 1'b1, 4'd7, 32'hDEADBEEF);
        drain();

        // 4: stalled consumer, buffer fills, third request held
        wr(4'd1, 32'd11);
        wr(4'd2, 32'd22);
        read_resp_ready = 1'b0;
        rd(4'd1, 32'd11, 1'b0);
        rd(4'd2, 32'd22, 1'b0);
        check("full_head_addr", 64'(read_resp_addr), 64'(1));
        read_req_valid = 1'b1;
        read_req_addr  = 4'd3;
        repeat (3) begin
            @(negedge clock);
            check("req_ready_full", 64'(read_req_ready), 64'(0));
        end
        @(posedge clock);
        #1;
        read_resp_ready = 1'b1;
        rd(4'd3, 32'd123, 1'b0);
        drain();

        // 5: queued response is a snapshot
        wr(4'd4, 32'd10);
        read_resp_ready = 1'b0;
        rd(4'd4, 32'd10, 1'b0);
        wr(4'd4, 32'd20);
        repeat (2) @(posedge clock);
        #1;
        read_resp_ready = 1'b1;
        drain();
        rd(4'd4, 32'd20, 1'b0);
        drain();

        // 6: out-of-range access and mid-cycle reset
        rd(4'd13, 32'd0, 1'b1);
        wr(4'd13, 32'h55);
        rd(4'd13, 32'd0, 1'b1);
        rd(4'd11, 32'd0, 1'b0);
        drain();
        read_resp_ready = 1'b0;
        rd(4'd3, 32'd123, 1'b0);
        rd(4'd4, 32'd20, 1'b0);
        check("pre_clear_valid", 64'(read_resp_valid), 64'(1));
        #2;
        clear = 1'b0;
        #1;
        check("clear_resp_valid", 64'(read_resp_valid), 64'(0));
        check("clear_req_ready",  64'(read_req_ready),  64'(0));
        check("clear_resp_data",  64'(read_resp_data),  64'(0));
        exp_q.delete();
        @(posedge clock);
        #1;
        clear = 1'b1;
        read_resp_ready = 1'b1;
        for (int i = 0; i < int'(NR); i++) begin
            rd(AW'(i), 32'd0, 1'b0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
